// File: rtl/cpu_bus_controller.sv
// cpu_bus_controller: decodes the CPU's per-M-cycle memory requests onto the
// external bus, OAM, I/O bus, internal HRAM and the IE register, and runs the
// OAM DMA engine (FF46), which takes over the external bus and OAM while copying.
module cpu_bus_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_read,
  output logic        ext_write,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write,
  input  logic [7:0]  oam_rdata,
  output logic [6:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_read,
  output logic        io_write,
  input  logic [7:0]  io_rdata,
  output logic [7:0]  ie_reg,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [7:0] DMA_LAST = 8'd159;

  dma_state_t state, state_next;
  logic [7:0] dma_idx, dma_idx_next;
  logic [7:0] dma_src;
  logic [7:0] dma_page;
  logic [7:0] dma_byte_p1;
  logic [7:0] rdata_p1;
  logic [7:0] rd_mux;
  logic [7:0] hram [0:126];
  logic       cycle_armed;

  logic is_t2, is_t3, access_ok, cpu_req;
  logic sel_ext, sel_oam, sel_unm, sel_io, sel_dma, sel_hram, sel_ie;
  logic dma_xfer, cpu_locked, dma_reg_wr;

  // Address decode and request qualification. A request is ignored for the
  // remainder of an M-cycle that was cut short by reset (cycle_armed low until
  // the next t_cycle 0).
  always_comb begin
    is_t2      = (t_cycle == 2'd2);
    is_t3      = (t_cycle == 2'd3);
    access_ok  = cycle_armed || (t_cycle == 2'd0);
    cpu_req    = cpu_mem_enable && access_ok;
    sel_ext    = (cpu_addr <= 16'hFDFF);
    sel_oam    = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    sel_unm    = (cpu_addr >= 16'hFEA0) && (cpu_addr <= 16'hFEFF);
    sel_dma    = (cpu_addr == 16'hFF46);
    sel_io     = (cpu_addr[15:7] == 9'h1FE) && !sel_dma;
    sel_hram   = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
    sel_ie     = (cpu_addr == 16'hFFFF);
    dma_reg_wr = cpu_req && cpu_mem_write && sel_dma;
  end

  // DMA state register; advances only on the edge ending t_cycle 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DMA_IDLE;
      dma_idx <= '0;
    end else begin
      state   <= state_next;
      dma_idx <= dma_idx_next;
    end
  end

  // DMA next state: an FF46 write always (re)enters START; otherwise step the copy.
  always_comb begin
    state_next   = state;
    dma_idx_next = dma_idx;
    if (is_t3) begin
      if (dma_reg_wr) begin
        state_next   = DMA_START;
        dma_idx_next = '0;
      end else begin
        case (state)
          DMA_START: begin
            state_next   = DMA_XFER;
            dma_idx_next = '0;
          end
          DMA_XFER: begin
            if (dma_idx == DMA_LAST) begin
              state_next   = DMA_IDLE;
              dma_idx_next = '0;
            end else begin
              dma_idx_next = dma_idx + 8'd1;
            end
          end
          default: begin
            state_next   = state;
            dma_idx_next = dma_idx;
          end
        endcase
      end
    end
  end

  // Bus strobes and addresses: DMA owns ext/OAM during XFER, CPU gets the rest.
  always_comb begin
    dma_active = (state != DMA_IDLE);
    dma_xfer   = (state == DMA_XFER);
    dma_page   = (dma_src > 8'hDF) ? (dma_src - 8'h20) : dma_src;
    cpu_locked = dma_xfer && (sel_ext || sel_oam || sel_unm);
    ext_addr   = '0;
    ext_wdata  = '0;
    ext_read   = 1'b0;
    ext_write  = 1'b0;
    oam_addr   = '0;
    oam_wdata  = '0;
    oam_write  = 1'b0;
    io_addr    = '0;
    io_wdata   = '0;
    io_read    = 1'b0;
    io_write   = 1'b0;
    if (dma_xfer) begin
      ext_addr  = {dma_page, dma_idx};
      ext_read  = 1'b1;
      oam_addr  = dma_idx;
      oam_wdata = dma_byte_p1;
      oam_write = is_t3;
    end else begin
      if (cpu_req && sel_ext) begin
        ext_addr  = cpu_addr;
        ext_read  = !cpu_mem_write;
        ext_write = cpu_mem_write && is_t3;
        ext_wdata = cpu_mem_write ? cpu_wdata : 8'h00;
      end
      if (cpu_req && sel_oam) begin
        oam_addr  = cpu_addr[7:0];
        oam_write = cpu_mem_write && is_t3;
        oam_wdata = cpu_mem_write ? cpu_wdata : 8'h00;
      end
    end
    if (cpu_req && sel_io) begin
      io_addr  = cpu_addr[6:0];
      io_read  = !cpu_mem_write;
      io_write = cpu_mem_write && is_t3;
      io_wdata = cpu_mem_write ? cpu_wdata : 8'h00;
    end
  end

  // CPU read data source selection; locked-out and unmapped regions read 0xFF.
  always_comb begin
    rd_mux = 8'hFF;
    if (!cpu_locked) begin
      if (sel_ext)       rd_mux = ext_rdata;
      else if (sel_oam)  rd_mux = oam_rdata;
      else if (sel_io)   rd_mux = io_rdata;
      else if (sel_dma)  rd_mux = dma_src;
      else if (sel_hram) rd_mux = hram[cpu_addr[6:0]];
      else if (sel_ie)   rd_mux = ie_reg;
    end
  end

  // Arm CPU requests once an M-cycle has been seen to start after reset.
  always_ff @(posedge clk) begin
    if (reset)                   cycle_armed <= 1'b0;
    else if (t_cycle == 2'd0)    cycle_armed <= 1'b1;
  end

  // Stage p1: read data latched at the end of t_cycle 2, held until the next one.
  always_ff @(posedge clk) begin
    if (reset)                               rdata_p1 <= 8'hFF;
    else if (is_t2 && cpu_req && !cpu_mem_write) rdata_p1 <= rd_mux;
  end

  assign cpu_rdata = rdata_p1;

  // Stage p1: DMA source byte captured at the end of t_cycle 2, written to OAM in t_cycle 3.
  always_ff @(posedge clk) begin
    if (dma_xfer && is_t2) dma_byte_p1 <= ext_rdata;
  end

  // FF46 source latch and IE register commit on the edge ending t_cycle 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_src <= 8'h00;
      ie_reg  <= 8'h00;
    end else if (is_t3 && cpu_req && cpu_mem_write) begin
      if (sel_dma) dma_src <= cpu_wdata;
      if (sel_ie)  ie_reg  <= cpu_wdata;
    end
  end

  // HRAM write port; contents survive reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && is_t3 && cpu_req && cpu_mem_write && sel_hram)
      hram[cpu_addr[6:0]] <= cpu_wdata;
  end

endmodule

// File: tb/tb_cpu_bus_controller.sv
// Bench for cpu_bus_controller: directed table, DMA corner sequences and
// randomized M-cycles compared against a region/phase-level reference model.
module tb_cpu_bus_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  t_cycle;
  logic        cpu_mem_enable, cpu_mem_write;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_read, ext_write;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_write;
  logic [6:0]  io_addr;
  logic [7:0]  io_wdata, io_rdata;
  logic        io_read, io_write;
  logic [7:0]  ie_reg;
  logic        dma_active;

  always #5 clk = ~clk;

  cpu_bus_controller dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle),
    .cpu_mem_enable(cpu_mem_enable), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_read(ext_read),
    .ext_write(ext_write), .ext_rdata(ext_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write(oam_write),
    .oam_rdata(oam_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read),
    .io_write(io_write), .io_rdata(io_rdata),
    .ie_reg(ie_reg), .dma_active(dma_active)
  );

  function automatic logic [7:0] ext_pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] oam_pat(input logic [7:0] a);
    return a ^ 8'h96;
  endfunction
  function automatic logic [7:0] io_pat(input logic [6:0] a);
    return {1'b1, a};
  endfunction

  // Peripheral responders: fixed content patterns keyed by address.
  always_comb begin
    ext_rdata = ext_pat(ext_addr);
    oam_rdata = oam_pat(oam_addr);
    io_rdata  = io_pat(io_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: DMA phase -1 = idle, 0 = start, 1..160 = copying byte phase-1.
  int         m_phase = -1;
  logic [7:0] m_src   = 8'h00;
  logic [7:0] m_ie    = 8'h00;
  logic [7:0] m_rdata = 8'hFF;
  logic [7:0] m_hram [0:126];
  int         oam_wr_seen = 0;

  // 0 ext, 1 oam, 2 unmapped, 3 io, 4 FF46, 5 hram, 6 ie
  function automatic int region(input logic [15:0] a);
    if (a < 16'hFE00) return 0;
    if (a < 16'hFEA0) return 1;
    if (a < 16'hFF00) return 2;
    if (a == 16'hFF46) return 4;
    if (a < 16'hFF80) return 3;
    if (a == 16'hFFFF) return 6;
    return 5;
  endfunction

  function automatic logic [7:0] model_read(input int rg, input logic [15:0] a);
    case (rg)
      0: return ext_pat(a);
      1: return oam_pat(a[7:0]);
      3: return io_pat(a[6:0]);
      4: return m_src;
      5: return m_hram[int'(a) - 32'hFF80];
      6: return m_ie;
      default: return 8'hFF;
    endcase
  endfunction

  // One M-cycle of CPU request, checked against the model phase by phase.
  task automatic mcycle(input logic en, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, output logic [7:0] got_rd,
                        output logic [15:0] got_ea, output logic [4:0] got_strb);
    int rg;
    logic xfer, locked, rd, wq;
    logic [7:0] idx, page, rv;
    rg     = region(addr);
    xfer   = (m_phase >= 1);
    idx    = 8'(m_phase - 1);
    page   = (m_src > 8'hDF) ? m_src - 8'h20 : m_src;
    locked = xfer && (rg <= 2);
    rd     = en && !wr;
    wq     = en && wr;
    rv     = locked ? 8'hFF : model_read(rg, addr);
    got_rd = 8'h00;
    got_ea = 16'h0000;
    got_strb = 5'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      t_cycle = 2'(t);
      if (t == 0) begin
        cpu_mem_enable = en; cpu_mem_write = wr; cpu_addr = addr; cpu_wdata = wd;
      end
      @(negedge clk);
      got_strb |= {ext_read, ext_write, io_read, io_write, oam_write};
      if (t == 1) begin
        check("dma_active", 32'(dma_active), 32'(m_phase >= 0));
        check("ext_read", 32'(ext_read), 32'(xfer || (rd && rg == 0 && !locked)));
        check("io_read", 32'(io_read), 32'(rd && rg == 3));
        check("wr_strobe_t1", 32'({ext_write, io_write, oam_write}), 32'h0);
        if (xfer) check("dma_ext_addr", 32'(ext_addr), 32'({page, idx}));
        else if (rd && rg == 0) check("ext_addr", 32'(ext_addr), 32'(addr));
        if (rd && rg == 3) check("io_addr_rd", 32'(io_addr), 32'(addr[6:0]));
        got_ea = ext_addr;
      end
      if (t == 3) begin
        check("ext_write", 32'(ext_write), 32'(wq && rg == 0 && !locked));
        check("io_write", 32'(io_write), 32'(wq && rg == 3));
        check("oam_write", 32'(oam_write), 32'(xfer || (wq && rg == 1 && !locked)));
        if (xfer) begin
          check("dma_oam_addr", 32'(oam_addr), 32'(idx));
          check("dma_oam_data", 32'(oam_wdata), 32'(ext_pat({page, idx})));
        end else if (wq && rg == 1) begin
          check("cpu_oam_addr", 32'(oam_addr), 32'(addr[7:0]));
          check("cpu_oam_data", 32'(oam_wdata), 32'(wd));
        end
        if (wq && rg == 0 && !locked) begin
          check("ext_waddr", 32'(ext_addr), 32'(addr));
          check("ext_wdata", 32'(ext_wdata), 32'(wd));
        end
        if (wq && rg == 3) begin
          check("io_waddr", 32'(io_addr), 32'(addr[6:0]));
          check("io_wdata", 32'(io_wdata), 32'(wd));
        end
        if (rd) m_rdata = rv;
        check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        check("ie_reg", 32'(ie_reg), 32'(m_ie));
        if (oam_write) oam_wr_seen++;
        got_rd = cpu_rdata;
      end
    end
    if (wq) begin
      case (rg)
        4: m_src = wd;
        5: m_hram[int'(addr) - 32'hFF80] = wd;
        6: m_ie = wd;
        default: ;
      endcase
    end
    if (wq && rg == 4) m_phase = 0;
    else if (m_phase >= 0) begin
      m_phase++;
      if (m_phase > 160) m_phase = -1;
    end
  endtask

  // M-cycle with reset pulsed during t_cycle 1; the rest of the cycle must be inert.
  task automatic mcycle_reset(input logic [15:0] addr, input logic [7:0] wd);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      t_cycle = 2'(t);
      if (t == 0) begin
        cpu_mem_enable = 1'b1; cpu_mem_write = 1'b1; cpu_addr = addr; cpu_wdata = wd;
      end
      if (t == 1) reset = 1'b1;
      if (t == 2) reset = 1'b0;
      @(negedge clk);
      if (t >= 2) begin
        check("rst_dma_active", 32'(dma_active), 32'h0);
        check("rst_strobes", 32'({ext_read, ext_write, io_read, io_write, oam_write}), 32'h0);
        check("rst_ie_reg", 32'(ie_reg), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
      end
    end
    m_phase = -1; m_src = 8'h00; m_ie = 8'h00; m_rdata = 8'hFF;
  endtask

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rdata;
    logic [4:0]  strb;   // {ext_read, ext_write, io_read, io_write, oam_write} seen during the M-cycle
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  logic [7:0]  r;
  logic [15:0] ea;
  logic [4:0]  s;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 16'hFF80, 8'h5A, 8'h00, 5'b00000};
    vecs[1]  = '{1'b1, 1'b1, 16'hFFFE, 8'hA5, 8'h00, 5'b00000};
    vecs[2]  = '{1'b1, 1'b0, 16'hFF80, 8'h00, 8'h5A, 5'b00000};
    vecs[3]  = '{1'b1, 1'b0, 16'hFFFE, 8'h00, 8'hA5, 5'b00000};
    vecs[4]  = '{1'b1, 1'b0, 16'hC123, 8'h00, 8'hDE, 5'b10000};
    vecs[5]  = '{1'b1, 1'b1, 16'hFF40, 8'h77, 8'h00, 5'b00010};
    vecs[6]  = '{1'b1, 1'b0, 16'hFEA5, 8'h00, 8'hFF, 5'b00000};
    vecs[7]  = '{1'b1, 1'b1, 16'hFFFF, 8'h1F, 8'h00, 5'b00000};
    vecs[8]  = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h1F, 5'b00000};
    vecs[9]  = '{1'b1, 1'b0, 16'hFF46, 8'h00, 8'h00, 5'b00000};
    vecs[10] = '{1'b1, 1'b0, 16'hFE10, 8'h00, 8'h86, 5'b00000};
    vecs[11] = '{1'b1, 1'b0, 16'hFF05, 8'h00, 8'h85, 5'b00100};
    vecs[12] = '{1'b1, 1'b1, 16'hC200, 8'h44, 8'h00, 5'b01000};
    vecs[13] = '{1'b1, 1'b1, 16'hFE20, 8'h55, 8'h00, 5'b00001};
    vecs[14] = '{1'b1, 1'b1, 16'hFEA0, 8'h12, 8'h00, 5'b00000};

    reset = 1'b1; t_cycle = 2'd0;
    cpu_mem_enable = 1'b0; cpu_mem_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", 32'({ext_read, ext_write, io_read, io_write, oam_write}), 32'h0);
    check("reset_addrs", 32'({ext_addr, oam_addr, 1'b0, io_addr}), 32'h0);
    check("reset_wdata", 32'({ext_wdata, oam_wdata, io_wdata}), 32'h0);
    check("reset_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    check("reset_dma_active", 32'(dma_active), 32'h0);
    check("reset_ie_reg", 32'(ie_reg), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Give every HRAM byte a known value.
    for (int i = 0; i < 127; i++)
      mcycle(1'b1, 1'b1, 16'hFF80 + 16'(i), 8'($urandom), r, ea, s);

    // Directed decode table.
    for (int i = 0; i < NV; i++) begin
      mcycle(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wd, r, ea, s);
      check($sformatf("tbl%0d_strb", i), 32'(s), 32'(vecs[i].strb));
      if (!vecs[i].wr) check($sformatf("tbl%0d_rdata", i), 32'(r), 32'(vecs[i].rdata));
      if (vecs[i].strb[4]) check($sformatf("tbl%0d_ext_addr", i), 32'(ea), 32'(vecs[i].addr));
    end

    // DMA from page C0: one START M-cycle, then 160 copies.
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hC0, r, ea, s);
    oam_wr_seen = 0;
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    check("c0_start_no_oam", 32'(s[0]), 32'h0);
    for (int i = 0; i < 160; i++) begin
      mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
      if (i == 0)   check("c0_first_src", 32'(ea), 32'hC000);
      if (i == 159) check("c0_last_src", 32'(ea), 32'hC09F);
    end
    check("c0_oam_writes", 32'(oam_wr_seen), 32'd160);
    mcycle(1'b1, 1'b0, 16'hFF46, 8'h00, r, ea, s);
    check("c0_ff46_read", 32'(r), 32'hC0);

    // Lockout with source page FE (mapped to DE).
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hFE, r, ea, s);
    mcycle(1'b1, 1'b0, 16'hC000, 8'h00, r, ea, s);
    check("start_cpu_ext_read", 32'(r), 32'hFC);
    mcycle(1'b1, 1'b0, 16'hC000, 8'h00, r, ea, s);
    check("lock_ext_read", 32'(r), 32'hFF);
    check("lock_dma_addr", 32'(ea), 32'hDE00);
    mcycle(1'b1, 1'b1, 16'hD000, 8'h99, r, ea, s);
    check("lock_no_ext_write", 32'(s[3]), 32'h0);
    mcycle(1'b1, 1'b1, 16'hFF90, 8'h33, r, ea, s);
    mcycle(1'b1, 1'b0, 16'hFF90, 8'h00, r, ea, s);
    check("lock_hram_rd", 32'(r), 32'h33);
    mcycle(1'b1, 1'b0, 16'hFE00, 8'h00, r, ea, s);
    check("lock_oam_read", 32'(r), 32'hFF);
    for (int k = 0; k < 170 && m_phase >= 0; k++)
      mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    check("lock_done", 32'(m_phase), 32'hFFFF_FFFF);

    // Restart at idx 50 with page C1.
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hC0, r, ea, s);
    for (int k = 0; k < 60 && m_phase != 51; k++)
      mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hC1, r, ea, s);
    check("restart_last_byte", 32'(s[0]), 32'h1);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    check("restart_start_no_oam", 32'(s[0]), 32'h0);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    check("restart_src", 32'(ea), 32'hC100);
    for (int k = 0; k < 170 && m_phase >= 0; k++)
      mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);

    // Reset in the middle of a copy at idx 80; a coinciding HRAM write is dropped.
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hC0, r, ea, s);
    for (int k = 0; k < 90 && m_phase != 81; k++)
      mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    mcycle_reset(16'hFF80, 8'hEE);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, r, ea, s);
    check("post_reset_no_oam", 32'(s[0]), 32'h0);
    mcycle(1'b1, 1'b0, 16'hFF80, 8'h00, r, ea, s);
    check("post_reset_hram_kept", 32'(r), 32'h5A);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      int sel;
      logic [15:0] a;
      sel = int'($urandom_range(0, 99));
      if (sel < 25)      a = 16'($urandom_range(0, 32'hFDFF));
      else if (sel < 35) a = 16'hFE00 + 16'($urandom_range(0, 159));
      else if (sel < 40) a = 16'hFEA0 + 16'($urandom_range(0, 95));
      else if (sel < 60) begin
        a = 16'hFF00 + 16'($urandom_range(0, 127));
        if (a == 16'hFF46) a = 16'hFF47;
      end
      else if (sel < 62) a = 16'hFF46;
      else if (sel < 85) a = 16'hFF80 + 16'($urandom_range(0, 126));
      else               a = 16'hFFFF;
      mcycle($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), a, 8'($urandom), r, ea, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
